main_memory_arbiter: RTL and testbench
======================================

Name: main_memory_arbiter

Overview:
- Round-robin arbiter sharing the single-port 32-bit x 65000-word on-chip main memory between NUM_REQ Avalon-MM-style requesters (e.g. Nios host, TED encryption engine, DMA).
- Issues at most one command per cycle and routes the 1-cycle-latency read data back to the requester that issued the read.
- Supports a per-requester lock for atomic read-modify-write sequences.
- Blocks out-of-range accesses and reports them through a sticky error flag.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 16, word-address width.
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- MEM_DEPTH, 65000, valid words; an address >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address; slice i = bits [i*ADDR_W +: ADDR_W].
- req_byteenable  in  NUM_REQ*DATA_W/8  per-requester byte enables.
- req_read  in  NUM_REQ  read request.
- req_write  in  NUM_REQ  write request.
- req_lock  in  NUM_REQ  hold grant after the current access.
- req_writedata  in  NUM_REQ*DATA_W  write data.
- req_waitrequest  out  NUM_REQ  command not accepted this cycle.
- req_readdata  out  DATA_W  shared read-return bus.
- req_readdatavalid  out  NUM_REQ  one-hot read-return strobe.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  DATA_W/8  to memory byteenable.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  from memory; valid the cycle after the address is presented.
- err_oob  out  1  sticky out-of-range flag.
- err_clear  in  1  clears err_oob.

Behaviour:
- Reset values: prio_ptr=0, lock_owner=none, rd_pend=0, err_oob=0, req_readdatavalid=0, req_readdata=0. req_waitrequest=1 for any requester currently asserting read|write, 0 otherwise.
- Active request: act[i] = req_read[i] | req_write[i].
- Grant selection is combinational within the cycle.
  - If lock_owner is valid, only lock_owner may be granted; all other requesters see waitrequest=1.
  - Otherwise the first active requester scanning from prio_ptr upward (modulo NUM_REQ) is granted.
- Granted requester g: req_waitrequest[g]=0 and the command is accepted this cycle. All other active requesters: waitrequest=1.
- Memory drive on an accepted command:
  - mem_address/byteenable/writedata are driven from g; mem_chipselect=1.
  - mem_write = req_write[g] & in-range.
  - No grant: chipselect=0, write=0, address holds its last value.
- Both read and write asserted by g: the write executes, the read is ignored, and err_oob is set.
- Out-of-range address (>= MEM_DEPTH):
  - Command is still accepted; mem_chipselect=0.
  - Reads return 0 with a normal readdatavalid.
  - err_oob is set.
- Read return latency is exactly 1 cycle. An accepted read at cycle N registers rd_pend=1, rd_owner=g, rd_oob. At cycle N+1: req_readdatavalid[rd_owner]=1; req_readdata = rd_oob ? 0 : mem_readdata (req_readdata is combinational from mem_readdata).
- Back-to-back reads (including from different requesters) sustain 1 per cycle; return order equals issue order.
- prio_ptr updates only on an accepted command: prio_ptr = (g+1) mod NUM_REQ. Holds when nothing is accepted.
- Lock:
  - After an accepted command with req_lock[g]=1, lock_owner = g.
  - lock_owner clears on an accepted command with req_lock[g]=0, or when req_lock[lock_owner] deasserts while idle.
  - While locked, prio_ptr does not advance past the owner.
- err_oob: set has priority over a simultaneous err_clear.
- Reset mid-operation: any pending read is discarded (no readdatavalid after reset) and the lock is released.
- Width rules: address compare is unsigned ADDR_W-bit; no arithmetic on data.

Decomposition:
- Shared package main_memory_pkg:
  - localparams MEM_ADDR_W=16, MEM_DATA_W=32, MEM_DEPTH=65000, MEM_BE_W=4.
  - function for the 1-hot to index encode.
- One sub-module, rr_priority_select: combinational round-robin picker (act, prio_ptr, lock_valid, lock_owner -> grant one-hot + index).

Test Plan:
- Single requester 0 writes 0xCAFEBABE to address 0x0010 (be=4'hF), then reads 0x0010 -> waitrequest=0 both cycles; readdatavalid[0]=1 exactly one cycle after the read with data 0xCAFEBABE; readdatavalid[1] stays 0.
- Both requesters read continuously from reset -> grants alternate 0,1,0,1; one readdatavalid per cycle, correct owner, no gaps.
- Requester 1 asserts lock and issues read 0x0100 then write 0x0100 while requester 0 reads continuously:
  - requester 0 waits until the locked write is accepted with req_lock=0;
  - no requester-0 access interleaves.
- Read of address 65000 (0xFDE8) -> mem_chipselect=0; readdatavalid with data 0; err_oob=1 and held; err_clear pulse -> 0; set and clear in the same cycle -> stays 1.
- Byte-enable write 0x11223344 with be=4'b0101 over existing 0xAAAAAAAA -> readback 0xAA22AA44.
- Read accepted, reset_n pulsed low on the next edge -> no readdatavalid; all outputs at reset values; prio_ptr=0.

Source files
------------

// File: rtl/main_memory_pkg.sv
// Shared constants, types and helpers for the main-memory arbiter slice.
// Sized for the 32-bit x 65000-word on-chip memory and up to four requesters.
package main_memory_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 65000;
  localparam int MEM_BE_W   = 4;

  localparam int MAX_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef struct packed {
    logic                 pend;
    logic [REQ_IDX_W-1:0] owner;
    logic                 oob;
  } rd_slot_t;

  function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    onehot_to_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) onehot_to_idx = REQ_IDX_W'(i);
    end
  endfunction

  function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx, input int num_req);
    rr_next = (int'(idx) + 1 >= num_req) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Requester-side and memory-side bus bundle of the main-memory arbiter.
// The arbiter takes the slave view; requesters plus the memory macro take the master view.
interface main_memory_arbiter_if
  import main_memory_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  logic [ADDR_W-1:0]         mem_address;
  logic [BE_W-1:0]           mem_byteenable;
  logic [DATA_W-1:0]         mem_writedata;
  logic                      mem_chipselect;
  logic                      mem_write;
  logic                      mem_clken;
  logic [DATA_W-1:0]         mem_readdata;

  modport slave (
    input  req_address, req_byteenable, req_read, req_write, req_lock, req_writedata,
           mem_readdata,
    output req_waitrequest, req_readdata, req_readdatavalid,
           mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken
  );

  modport master (
    output req_address, req_byteenable, req_read, req_write, req_lock, req_writedata,
           mem_readdata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
           mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: grants the first active requester at or after
// prio_ptr, or only the lock owner while a lock is held.
module rr_priority_select
  import main_memory_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [MAX_REQ-1:0]   act,
  input  logic [REQ_IDX_W-1:0] prio_ptr,
  input  logic                 lock_valid,
  input  logic [REQ_IDX_W-1:0] lock_owner,
  output logic [MAX_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] grant_idx,
  output logic                 grant_valid
);

  logic [REQ_IDX_W-1:0] scan_idx;
  logic                 found;

  always_comb begin
    grant    = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (lock_valid) begin
      grant[lock_owner] = act[lock_owner];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = REQ_IDX_W'((int'(prio_ptr) + k) % NUM_REQ);
        if (!found && act[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

  assign grant_idx   = onehot_to_idx(grant);
  assign grant_valid = |grant;

endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing the single-port main memory between NUM_REQ requesters,
// with per-requester locking, 1-cycle read return routing and sticky out-of-range error.
module main_memory_arbiter
  import main_memory_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MEM_DEPTH = main_memory_pkg::MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  main_memory_arbiter_if.slave  bus,
  input  logic                  err_clear,
  output logic                  err_oob
);

  localparam int BE_W = DATA_W / 8;

  logic [MAX_REQ-1:0]   rd_wide, wr_wide, lock_wide, act_wide, grant_wide, rdv_wide;
  logic [ADDR_W-1:0]    addr_arr  [MAX_REQ];
  logic [BE_W-1:0]      be_arr    [MAX_REQ];
  logic [DATA_W-1:0]    wdata_arr [MAX_REQ];

  logic [REQ_IDX_W-1:0] prio_ptr, lock_owner, grant_idx;
  logic                 lock_valid, grant_valid, accept;
  logic                 sel_rd, sel_wr, sel_in_range;
  logic [ADDR_W-1:0]    sel_addr, addr_hold;
  rd_slot_t             rd_q;

  assign rd_wide   = MAX_REQ'(bus.req_read);
  assign wr_wide   = MAX_REQ'(bus.req_write);
  assign lock_wide = MAX_REQ'(bus.req_lock);
  assign act_wide  = rd_wide | wr_wide;

  // Unpack the flat per-requester buses; unused slots read as zero.
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
    if (i < NUM_REQ) begin : g_live
      assign addr_arr[i]  = bus.req_address[i*ADDR_W +: ADDR_W];
      assign be_arr[i]    = bus.req_byteenable[i*BE_W +: BE_W];
      assign wdata_arr[i] = bus.req_writedata[i*DATA_W +: DATA_W];
    end else begin : g_unused
      assign addr_arr[i]  = '0;
      assign be_arr[i]    = '0;
      assign wdata_arr[i] = '0;
    end
  end

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .act         (act_wide),
    .prio_ptr    (prio_ptr),
    .lock_valid  (lock_valid),
    .lock_owner  (lock_owner),
    .grant       (grant_wide),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // No command is accepted while reset is held, so every active requester waits.
  assign accept       = grant_valid & reset_n;
  assign sel_addr     = addr_arr[grant_idx];
  assign sel_wr       = wr_wide[grant_idx];
  assign sel_rd       = rd_wide[grant_idx] & ~sel_wr;
  assign sel_in_range = 32'(sel_addr) < 32'(MEM_DEPTH);

  assign bus.req_waitrequest = (bus.req_read | bus.req_write)
                             & ~(grant_wide[NUM_REQ-1:0] & {NUM_REQ{reset_n}});

  assign bus.mem_address    = accept ? sel_addr : addr_hold;
  assign bus.mem_byteenable = be_arr[grant_idx];
  assign bus.mem_writedata  = wdata_arr[grant_idx];
  assign bus.mem_chipselect = accept & sel_in_range;
  assign bus.mem_write      = accept & sel_wr & sel_in_range;
  assign bus.mem_clken      = 1'b1;

  assign rdv_wide              = rd_q.pend ? (MAX_REQ'(1) << rd_q.owner) : '0;
  assign bus.req_readdatavalid = rdv_wide[NUM_REQ-1:0];
  assign bus.req_readdata      = (rd_q.pend && !rd_q.oob) ? bus.mem_readdata : '0;

  // Arbitration state: pointer, lock, one read slot in flight and the sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_ptr   <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      rd_q       <= '0;
      addr_hold  <= '0;
      err_oob    <= 1'b0;
    end else begin
      rd_q.pend  <= accept & sel_rd;
      rd_q.owner <= grant_idx;
      rd_q.oob   <= ~sel_in_range;
      if (accept) begin
        prio_ptr   <= rr_next(grant_idx, NUM_REQ);
        lock_valid <= lock_wide[grant_idx];
        lock_owner <= grant_idx;
        addr_hold  <= sel_addr;
      end else if (lock_valid && !lock_wide[lock_owner]) begin
        lock_valid <= 1'b0;
      end
      if (accept && (!sel_in_range || (rd_wide[grant_idx] && sel_wr))) begin
        err_oob <= 1'b1;
      end else if (err_clear) begin
        err_oob <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed self-checking bench for main_memory_arbiter with a behavioural
// 1-cycle-latency memory attached to the memory-side bus.
module tb_main_memory_arbiter;

  logic clk;
  logic reset_n;
  logic err_clear;
  logic err_oob;

  int compared;
  int mismatched;

  logic [31:0] tb_mem [65536];
  logic [31:0] mem_rdata_q;

  logic [1:0] exp_wait [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [1:0] exp_rdv  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

  main_memory_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32)) bus ();

  main_memory_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32), .MEM_DEPTH(65000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_clear (err_clear),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: registered read, byte-masked write, both gated by chipselect.
  initial mem_rdata_q = '0;
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_byteenable[b]) tb_mem[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
        end
      end
      mem_rdata_q <= tb_mem[bus.mem_address];
    end
  end
  assign bus.mem_readdata = mem_rdata_q;

  task automatic applyStimulus(input int idx, input logic rd, input logic wr, input logic lk,
                               input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.req_read[idx]                = rd;
    bus.req_write[idx]               = wr;
    bus.req_lock[idx]                = lk;
    bus.req_address[idx*16 +: 16]    = addr;
    bus.req_writedata[idx*32 +: 32]  = wdata;
    bus.req_byteenable[idx*4 +: 4]   = be;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    err_clear  = 1'b0;
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_lock       = '0;
    bus.req_address    = '0;
    bus.req_writedata  = '0;
    bus.req_byteenable = '0;

    // Reset state with both requesters already asking to read.
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'h0010, 32'h0, 4'hF);
    applyStimulus(1, 1, 0, 0, 16'h0020, 32'h0, 4'hF);
    #1;
    checkOutput("rst_wait", 32'(bus.req_waitrequest), 32'h3);
    checkOutput("rst_cs",   32'(bus.mem_chipselect), 32'h0);
    checkOutput("rst_rdv",  32'(bus.req_readdatavalid), 32'h0);
    checkOutput("rst_rdata", bus.req_readdata, 32'h0);
    checkOutput("rst_err",  32'(err_oob), 32'h0);

    // Continuous reads from both requesters alternate grants.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) reset_n = 1'b1;
      #1;
      checkOutput($sformatf("rr_wait%0d", k), 32'(bus.req_waitrequest), 32'(exp_wait[k]));
      checkOutput($sformatf("rr_rdv%0d", k), 32'(bus.req_readdatavalid), 32'(exp_rdv[k]));
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0010, 32'h0, 4'hF);
    applyStimulus(1, 0, 0, 0, 16'h0020, 32'h0, 4'hF);

    // Single requester write then read-back.
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 16'h0010, 32'hCAFEBABE, 4'hF);
    #1;
    checkOutput("wr_wait", 32'(bus.req_waitrequest), 32'h0);
    checkOutput("wr_memwrite", 32'(bus.mem_write), 32'h1);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'h0010, 32'h0, 4'hF);
    #1;
    checkOutput("rd_wait", 32'(bus.req_waitrequest), 32'h0);
    checkOutput("rd_memwrite", 32'(bus.mem_write), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0010, 32'h0, 4'hF);
    #1;
    checkOutput("rd_rdv", 32'(bus.req_readdatavalid), 32'h1);
    checkOutput("rd_data", bus.req_readdata, 32'hCAFEBABE);
    @(negedge clk);
    #1;
    checkOutput("rd_rdv_once", 32'(bus.req_readdatavalid), 32'h0);

    // Requester 1 locks across read, idle and write while requester 0 keeps reading.
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'h0010, 32'h0, 4'hF);
    applyStimulus(1, 1, 0, 1, 16'h0100, 32'h0, 4'hF);
    #1;
    checkOutput("lk_c1_wait", 32'(bus.req_waitrequest), 32'h1);
    @(negedge clk);
    applyStimulus(1, 0, 0, 1, 16'h0100, 32'h0, 4'hF);
    #1;
    checkOutput("lk_c2_wait", 32'(bus.req_waitrequest), 32'h1);
    checkOutput("lk_c2_rdv", 32'(bus.req_readdatavalid), 32'h2);
    @(negedge clk);
    applyStimulus(1, 0, 1, 0, 16'h0100, 32'h55550000, 4'hF);
    #1;
    checkOutput("lk_c3_wait", 32'(bus.req_waitrequest), 32'h1);
    checkOutput("lk_c3_memwrite", 32'(bus.mem_write), 32'h1);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 16'h0100, 32'h0, 4'hF);
    #1;
    checkOutput("lk_c4_wait", 32'(bus.req_waitrequest), 32'h0);
    checkOutput("lk_c4_rdv", 32'(bus.req_readdatavalid), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0010, 32'h0, 4'hF);
    #1;
    checkOutput("lk_c5_rdv", 32'(bus.req_readdatavalid), 32'h1);
    checkOutput("lk_c5_data", bus.req_readdata, 32'hCAFEBABE);

    // Byte-enable merge over an existing word.
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 16'h0200, 32'hAAAAAAAA, 4'hF);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 16'h0200, 32'h11223344, 4'b0101);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'h0200, 32'h0, 4'hF);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0200, 32'h0, 4'hF);
    #1;
    checkOutput("be_rdv", 32'(bus.req_readdatavalid), 32'h1);
    checkOutput("be_data", bus.req_readdata, 32'hAA22AA44);

    // Out-of-range access, sticky error, clear, and set-beats-clear.
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'hFDE8, 32'h0, 4'hF);
    #1;
    checkOutput("oob_cs", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("oob_wait", 32'(bus.req_waitrequest), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'hFDE8, 32'h0, 4'hF);
    #1;
    checkOutput("oob_rdv", 32'(bus.req_readdatavalid), 32'h1);
    checkOutput("oob_data", bus.req_readdata, 32'h0);
    checkOutput("oob_err", 32'(err_oob), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("oob_err_held", 32'(err_oob), 32'h1);
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    checkOutput("oob_err_cleared", 32'(err_oob), 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'hFDE8, 32'h0, 4'hF);
    err_clear = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'hFDE7, 32'h0, 4'hF);
    err_clear = 1'b0;
    #1;
    checkOutput("oob_set_wins", 32'(err_oob), 32'h1);
    checkOutput("edge_cs", 32'(bus.mem_chipselect), 32'h1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0000, 32'h0, 4'hF);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    applyStimulus(0, 1, 1, 0, 16'h0300, 32'h12345678, 4'hF);
    #1;
    checkOutput("rw_memwrite", 32'(bus.mem_write), 32'h1);
    checkOutput("rw_err_before", 32'(err_oob), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 16'h0300, 32'h0, 4'hF);
    #1;
    checkOutput("rw_err", 32'(err_oob), 32'h1);
    checkOutput("rw_no_rdv", 32'(bus.req_readdatavalid), 32'h0);

    // Reset right after an accepted read discards it and restores the pointer.
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 16'h0010, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 16'h0020, 32'h0, 4'hF);
    #1;
    checkOutput("mid_rst_rdv", 32'(bus.req_readdatavalid), 32'h0);
    checkOutput("mid_rst_rdata", bus.req_readdata, 32'h0);
    checkOutput("mid_rst_cs", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("mid_rst_wait", 32'(bus.req_waitrequest), 32'h3);
    checkOutput("mid_rst_err", 32'(err_oob), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_wait", 32'(bus.req_waitrequest), 32'h2);
    checkOutput("post_rst_cs", 32'(bus.mem_chipselect), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("post_rst_rdv", 32'(bus.req_readdatavalid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
